// File: rtl/pdm_capture_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : pdm_capture_pkg                                            |
// | Purpose : Shared definitions for the PDM frame capture block: the    |
// |           capture state encoding, parameter defaults and a width     |
// |           helper used by the top level and the sample FIFO.          |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package pdm_capture_pkg;

  localparam int CLK_DIV_DEFAULT    = 40;
  localparam int DECIM_DEFAULT      = 64;
  localparam int SAMPLE_W_DEFAULT   = 16;
  localparam int FRAME_LEN_DEFAULT  = 1024;
  localparam int FIFO_DEPTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  // Bits needed to count 0..value-1, never less than one.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : sync_fifo                                                  |
// | Purpose : Single-clock show-ahead FIFO with a registered read port.  |
// |           The head entry is always present on rd_data while empty   |
// |           is low; a pop and a push may happen together even when     |
// |           the FIFO is full (the pop frees the slot).                 |
// | Ports   : clk_in, rst_in (sync, active high)                         |
// |           wr_en, wr_data, full   - write side                        |
// |           rd_en, rd_data, empty  - read side (rd_en = pop the head)  |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module sync_fifo
  import pdm_capture_pkg::*;
#(
  parameter int WIDTH = 17,
  parameter int DEPTH = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int AW = clog2_min1(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  logic          rd_ok;
  logic          wr_ok;
  logic [AW-1:0] next_rd_ptr;

  assign empty       = (count == '0);
  assign full        = (count == (AW+1)'(DEPTH));
  assign rd_ok       = rd_en && !empty;
  // A pop in the same cycle frees the slot the write needs.
  assign wr_ok       = wr_en && (!full || rd_ok);
  assign next_rd_ptr = rd_ok ? rd_ptr + AW'(1) : rd_ptr;

  always_ff @(posedge clk_in) begin
    if (wr_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr <= next_rd_ptr;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      // The output register follows the head.  When the new head is the
      // entry being written this cycle the memory does not hold it yet, so
      // it is taken straight from wr_data.  Without a push or pop the head
      // is untouched and rd_data holds, which keeps it stable under stall.
      if (wr_ok && (wr_ptr == next_rd_ptr)) begin
        rd_data <= wr_data;
      end else if (rd_ok) begin
        rd_data <= mem[next_rd_ptr];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pdm_frame_capture.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : pdm_frame_capture                                          |
// | Purpose : Generates a PDM microphone clock, decimates the PDM bit    |
// |           stream into signed samples (2*ones - DECIM per window) and |
// |           streams frames of FRAME_LEN samples out over a valid/ready |
// |           interface through a small FIFO.                            |
// | Ports   : clk_in, rst_in      clock, sync active-high reset          |
// |           record_in           level request to capture               |
// |           mic_data_in         PDM bit from microphone                |
// |           mic_clk_out         generated microphone clock             |
// |           m_tdata/m_tvalid/m_tready/m_tlast  sample stream           |
// |           overflow_out        sticky sample-dropped flag             |
// |           frame_count_out     frames delivered (tlast handshakes)    |
// |           busy_out            high whenever not idle                 |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module pdm_frame_capture
  import pdm_capture_pkg::*;
#(
  parameter int CLK_DIV    = CLK_DIV_DEFAULT,
  parameter int DECIM      = DECIM_DEFAULT,
  parameter int SAMPLE_W   = SAMPLE_W_DEFAULT,
  parameter int FRAME_LEN  = FRAME_LEN_DEFAULT,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                record_in,
  input  logic                mic_data_in,
  output logic                mic_clk_out,
  output logic [SAMPLE_W-1:0] m_tdata,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic                m_tlast,
  output logic                overflow_out,
  output logic [15:0]         frame_count_out,
  output logic                busy_out
);

  localparam int CW   = clog2_min1(CLK_DIV);
  localparam int HALF = CLK_DIV / 2;
  localparam int BW   = clog2_min1(DECIM);
  localparam int OW   = $clog2(DECIM + 1);
  localparam int IW   = clog2_min1(FRAME_LEN);

  state_t state;
  state_t state_next;

  logic [CW-1:0]       div_cnt;
  logic                strobe;
  logic                record_prev;
  logic                record_rise;
  logic                capture_strobe;
  logic                window_end;
  logic [BW-1:0]       bit_cnt;
  logic [OW-1:0]       ones;
  logic [OW-1:0]       ones_total;
  logic [SAMPLE_W-1:0] sample_value;
  logic [IW-1:0]       frame_idx;

  logic                pend_valid;
  logic                pend_last;
  logic [SAMPLE_W-1:0] pend_data;

  logic                fifo_full;
  logic                fifo_empty;
  logic [SAMPLE_W:0]   fifo_rd_data;
  logic                pop;
  logic                push_drop;

  // ---------------- microphone clock divider ----------------
  assign strobe = (div_cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      div_cnt     <= '0;
      mic_clk_out <= 1'b1;
    end else begin
      div_cnt     <= strobe ? '0 : div_cnt + CW'(1);
      mic_clk_out <= (div_cnt < CW'(HALF));
    end
  end

  // ---------------- decimation ----------------
  assign record_rise    = record_in && !record_prev;
  // The strobe that moves ARM to CAPTURE already carries bit 0.
  assign capture_strobe = strobe && ((state == ST_ARM) || (state == ST_CAPTURE));
  assign window_end     = capture_strobe && (bit_cnt == BW'(DECIM - 1));
  assign ones_total     = ones + OW'(mic_data_in);
  assign sample_value   = SAMPLE_W'({ones_total, 1'b0}) - SAMPLE_W'(DECIM);

  // ---------------- output buffer ----------------
  assign pop       = m_tvalid && m_tready;
  assign push_drop = pend_valid && fifo_full && !pop;

  sync_fifo #(
    .WIDTH (SAMPLE_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .wr_en   (pend_valid),
    .wr_data ({pend_last, pend_data}),
    .full    (fifo_full),
    .rd_en   (m_tready),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty)
  );

  assign m_tvalid          = !fifo_empty;
  assign {m_tlast, m_tdata} = fifo_rd_data;
  assign busy_out          = (state != ST_IDLE);

  // ---------------- control FSM ----------------
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (record_rise) state_next = ST_ARM;
      ST_ARM:     if (strobe) state_next = ST_CAPTURE;
      // Only the cycle that pushes (or drops) the frame's last sample may
      // end a capture, so a frame is never cut short.
      ST_CAPTURE: if (pend_valid && pend_last && !record_in) state_next = ST_DRAIN;
      ST_DRAIN:   if (fifo_empty && !pend_valid) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      record_prev     <= 1'b0;
      bit_cnt         <= '0;
      ones            <= '0;
      frame_idx       <= '0;
      pend_valid      <= 1'b0;
      pend_last       <= 1'b0;
      pend_data       <= '0;
      overflow_out    <= 1'b0;
      frame_count_out <= '0;
    end else begin
      record_prev <= record_in;
      // The completed sample waits one cycle in the pending register
      // before it is offered to the FIFO.
      pend_valid  <= window_end;

      if (window_end) begin
        pend_data <= sample_value;
        pend_last <= (frame_idx == IW'(FRAME_LEN - 1));
        frame_idx <= (frame_idx == IW'(FRAME_LEN - 1)) ? '0 : frame_idx + IW'(1);
        ones      <= '0;
        bit_cnt   <= '0;
      end else if (capture_strobe) begin
        ones    <= ones_total;
        bit_cnt <= bit_cnt + BW'(1);
      end else if ((state == ST_IDLE) || (state == ST_ARM)) begin
        ones      <= '0;
        bit_cnt   <= '0;
        frame_idx <= '0;
      end

      if ((state == ST_IDLE) && record_rise) begin
        overflow_out <= 1'b0;
      end else if (push_drop) begin
        overflow_out <= 1'b1;
      end

      if (pop && m_tlast) begin
        frame_count_out <= frame_count_out + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pdm_frame_capture.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_pdm_frame_capture                                       |
// | Purpose : Self-checking bench for pdm_frame_capture with a small     |
// |           configuration.  The PDM stream is logged per microphone    |
// |           clock period and expected samples are computed as sums of  |
// |           DECIM consecutive logged bits.                             |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_pdm_frame_capture;

  localparam int CLK_DIV    = 4;
  localparam int DECIM      = 8;
  localparam int SAMPLE_W   = 16;
  localparam int FRAME_LEN  = 4;
  localparam int FIFO_DEPTH = 4;

  logic                clk_in = 1'b0;
  logic                rst_in;
  logic                record_in;
  logic                mic_data_in;
  logic                mic_clk_out;
  logic [SAMPLE_W-1:0] m_tdata;
  logic                m_tvalid;
  logic                m_tready;
  logic                m_tlast;
  logic                overflow_out;
  logic [15:0]         frame_count_out;
  logic                busy_out;

  always #5 clk_in = ~clk_in;

  pdm_frame_capture #(
    .CLK_DIV    (CLK_DIV),
    .DECIM      (DECIM),
    .SAMPLE_W   (SAMPLE_W),
    .FRAME_LEN  (FRAME_LEN),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .record_in       (record_in),
    .mic_data_in     (mic_data_in),
    .mic_clk_out     (mic_clk_out),
    .m_tdata         (m_tdata),
    .m_tvalid        (m_tvalid),
    .m_tready        (m_tready),
    .m_tlast         (m_tlast),
    .overflow_out    (overflow_out),
    .frame_count_out (frame_count_out),
    .busy_out        (busy_out)
  );

  int total  = 0;
  int bad    = 0;
  int tb_cnt = 0;   // position inside the microphone clock period
  int per    = 0;   // microphone clock period number
  int mic_mode = 0; // 0 ones, 1 zeros, 2 alternating, 3 random
  int exp_fc = 0;
  bit bit_hist [4096];

  // One new PDM bit per microphone clock period, logged for the model.
  initial begin : mic_driver
    logic b;
    mic_data_in = 1'b0;
    forever begin
      @(posedge clk_in);
      if (rst_in) tb_cnt = 0;
      else        tb_cnt = (tb_cnt + 1) % CLK_DIV;
      if (tb_cnt == 0) begin
        per = per + 1;
        case (mic_mode)
          0:       b = 1'b1;
          1:       b = 1'b0;
          2:       b = 1'(per % 2);
          default: b = 1'($urandom_range(0, 1));
        endcase
        bit_hist[per % 4096] = b;
        #1 mic_data_in = b;
      end
    end
  end

  // Expected n-th sample of a capture whose first bit came from period sp.
  function automatic int exp_sample(input int sp, input int n);
    int ones = 0;
    for (int j = 0; j < DECIM; j++) ones += int'(bit_hist[(sp + DECIM * n + j) % 4096]);
    return 2 * ones - DECIM;
  endfunction

  task automatic test_reset();
    rst_in = 1'b1; record_in = 1'b0; m_tready = 1'b0;
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b0;
    total += 7;
    if (m_tvalid !== 1'b0)         begin bad++; $display("FAIL reset_tvalid: got %b want 0", m_tvalid); end
    if (m_tlast !== 1'b0)          begin bad++; $display("FAIL reset_tlast: got %b want 0", m_tlast); end
    if (m_tdata !== '0)            begin bad++; $display("FAIL reset_tdata: got %h want 0", m_tdata); end
    if (overflow_out !== 1'b0)     begin bad++; $display("FAIL reset_overflow: got %b want 0", overflow_out); end
    if (frame_count_out !== 16'd0) begin bad++; $display("FAIL reset_fcount: got %0d want 0", frame_count_out); end
    if (busy_out !== 1'b0)         begin bad++; $display("FAIL reset_busy: got %b want 0", busy_out); end
    if (mic_clk_out !== 1'b1)      begin bad++; $display("FAIL reset_micclk: got %b want 1", mic_clk_out); end
  endtask

  // mic_clk_out shows, one cycle late, whether the divider was in its first half.
  task automatic test_mic_clock();
    logic e;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk_in); #1;
      e = (((tb_cnt + CLK_DIV - 1) % CLK_DIV) < CLK_DIV / 2);
      total++;
      if (mic_clk_out !== e) begin bad++; $display("FAIL mic_clk: got %b want %b at phase %0d", mic_clk_out, e, tb_cnt); end
    end
  endtask

  // One capture: record_in drops in the middle of window drop_win; keep
  // samples (indices 0..keep-1) must be delivered in order.
  // rdy_mode 0: always ready, 1: random, 2: stalled until period sp+rel_off.
  task automatic test_capture(input int mode, input int drop_win, input int rdy_mode,
                              input int rel_off, input int keep, input bit exp_ovf);
    int sp, got, cyc, extra;
    bit stalled, done;
    logic [15:0] held_d, ed;
    logic held_l, el;
    mic_mode = mode;
    record_in = 1'b0;
    m_tready = (rdy_mode == 0);
    do begin @(posedge clk_in); #1; end while (tb_cnt != 0);
    record_in = 1'b1;
    sp = per; got = 0; cyc = 0; stalled = 1'b0; done = 1'b0;
    held_d = '0; held_l = 1'b0;
    while (!done) begin
      @(posedge clk_in); #1; cyc++;
      if (per >= sp + DECIM * drop_win + DECIM / 2) record_in = 1'b0;
      case (rdy_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = 1'($urandom_range(0, 1));
        default: m_tready = (per >= sp + rel_off);
      endcase
      if (cyc == 1) begin
        total++;
        if (overflow_out !== 1'b0) begin bad++; $display("FAIL ovf_clear_on_start: got %b want 0", overflow_out); end
      end
      if (per == sp + DECIM && tb_cnt == 0) begin
        total++;
        if (m_tvalid !== 1'b0) begin bad++; $display("FAIL latency_early: tvalid %b want 0", m_tvalid); end
      end
      if (per == sp + DECIM && tb_cnt == 1) begin
        total++;
        if (m_tvalid !== 1'b1) begin bad++; $display("FAIL latency_first: tvalid %b want 1", m_tvalid); end
      end
      total++;
      if (frame_count_out !== 16'(exp_fc)) begin
        bad++; $display("FAIL frame_count: got %0d want %0d", frame_count_out, exp_fc);
      end
      if (stalled) begin
        total++;
        if (m_tvalid !== 1'b1 || m_tdata !== held_d || m_tlast !== held_l) begin
          bad++; $display("FAIL stall_stable: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                          m_tvalid, m_tdata, m_tlast, held_d, held_l);
        end
      end
      if (m_tvalid && m_tready) begin
        ed = 16'(exp_sample(sp, got));
        el = ((got % FRAME_LEN) == FRAME_LEN - 1);
        total++;
        if (m_tdata !== ed || m_tlast !== el) begin
          bad++; $display("FAIL sample_%0d: got d=%h l=%b want d=%h l=%b", got, m_tdata, m_tlast, ed, el);
        end
        if (el) exp_fc++;
        got++;
      end
      stalled = m_tvalid && !m_tready;
      held_d = m_tdata; held_l = m_tlast;
      if (!busy_out && got >= keep) done = 1'b1;
      if (cyc > 3000) begin
        total++; bad++; done = 1'b1;
        $display("FAIL capture_timeout: got %0d samples busy=%b want %0d samples busy=0", got, busy_out, keep);
      end
    end
    total += 2;
    if (got != keep) begin bad++; $display("FAIL sample_count: got %0d want %0d", got, keep); end
    if (overflow_out !== exp_ovf) begin bad++; $display("FAIL overflow_end: got %b want %b", overflow_out, exp_ovf); end
    m_tready = 1'b1; extra = 0;
    repeat (2 * DECIM * CLK_DIV) begin
      @(posedge clk_in); #1;
      if (m_tvalid || busy_out) extra++;
    end
    total++;
    if (extra != 0) begin bad++; $display("FAIL idle_after_drain: got %0d active cycles want 0", extra); end
  endtask

  // Reset in the middle of a stalled, overflowing capture.
  task automatic test_reset_mid();
    int sp, leak, cyc;
    mic_mode = 3; record_in = 1'b0; m_tready = 1'b0;
    do begin @(posedge clk_in); #1; end while (tb_cnt != 0);
    record_in = 1'b1; sp = per; cyc = 0;
    while (per < sp + DECIM * 6 + 2 && cyc < 1000) begin @(posedge clk_in); #1; cyc++; end
    total += 2;
    if (m_tvalid !== 1'b1)     begin bad++; $display("FAIL pre_reset_tvalid: got %b want 1", m_tvalid); end
    if (overflow_out !== 1'b1) begin bad++; $display("FAIL pre_reset_overflow: got %b want 1", overflow_out); end
    rst_in = 1'b1; record_in = 1'b0;
    @(posedge clk_in); #1 rst_in = 1'b0;
    exp_fc = 0;
    total += 6;
    if (m_tvalid !== 1'b0)         begin bad++; $display("FAIL midrst_tvalid: got %b want 0", m_tvalid); end
    if (m_tlast !== 1'b0)          begin bad++; $display("FAIL midrst_tlast: got %b want 0", m_tlast); end
    if (m_tdata !== '0)            begin bad++; $display("FAIL midrst_tdata: got %h want 0", m_tdata); end
    if (frame_count_out !== 16'd0) begin bad++; $display("FAIL midrst_fcount: got %0d want 0", frame_count_out); end
    if (overflow_out !== 1'b0)     begin bad++; $display("FAIL midrst_overflow: got %b want 0", overflow_out); end
    if (busy_out !== 1'b0)         begin bad++; $display("FAIL midrst_busy: got %b want 0", busy_out); end
    m_tready = 1'b1; leak = 0;
    repeat (3 * DECIM * CLK_DIV) begin
      @(posedge clk_in); #1;
      if (m_tvalid || busy_out) leak++;
    end
    total++;
    if (leak != 0) begin bad++; $display("FAIL midrst_leak: got %0d active cycles want 0", leak); end
  endtask

  initial begin
    rst_in = 1'b1; record_in = 1'b0; m_tready = 1'b0;
    test_reset();
    test_mic_clock();
    test_capture(0, 9, 0, 0, 12, 1'b0);                 // all ones, three frames
    test_capture(1, 1, 0, 0, 4, 1'b0);                  // all zeros
    test_capture(2, 2, 0, 0, 4, 1'b0);                  // alternating, stop after 2nd
    test_capture(3, 0, 1, 0, 4, 1'b0);                  // random bits, random ready
    test_capture(3, 6, 1, 0, 8, 1'b0);
    test_capture(3, 5, 2, DECIM * 8 + 2, 4, 1'b1);      // stall through 8 windows
    test_capture(3, 5, 2, DECIM * 5, 8, 1'b0);          // release on push into full FIFO
    test_reset_mid();
    test_capture(3, 3, 1, 0, 4, 1'b0);                  // restarts at index 0
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
